strand_decoder: RTL and testbench

- Receive side of the single-wire NRZ LED strand protocol; recovers 24-bit GRB pixels from the serial line.
- Used to check the strand driver in loopback: PMOD output wired to a PMOD input, or the DOUT of the last LED in the chain fed back.
- Measures the high-pulse width of each bit, shifts bits MSB-first, emits one pixel per 24 bits, and flags frame-end on the latch (reset) low period.
- Timing is set in clk_in cycles; defaults are for 100 MHz.

---
 rtl/strand_decoder.sv | 138 +++++++++++++
 tb/tb_strand_decoder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/strand_decoder.sv
// Receive side of the single-wire NRZ LED strand protocol: measures high-pulse
// widths, shifts GRB bits MSB-first, and strobes pixels, frame end and errors.
module strand_decoder #(
    parameter int NUM_LEDS             = 10,
    parameter int BIT_THRESHOLD_CYCLES = 60,
    parameter int MIN_HIGH_CYCLES      = 20,
    parameter int MAX_HIGH_CYCLES      = 110,
    parameter int RESET_CYCLES         = 5000,
    localparam int IW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          strand_in,
    output logic [7:0]    green_out,
    output logic [7:0]    red_out,
    output logic [7:0]    blue_out,
    output logic [IW-1:0] led_index_out,
    output logic          pixel_valid_out,
    output logic          frame_done_out,
    output logic          error_out
);
    localparam int PW   = $clog2(NUM_LEDS + 1);
    localparam int CMAX = (RESET_CYCLES > MAX_HIGH_CYCLES + 1) ? RESET_CYCLES : MAX_HIGH_CYCLES + 1;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] ONE    = CW'(1);
    localparam logic [CW-1:0] RST_C  = CW'(RESET_CYCLES);
    localparam logic [CW-1:0] RST_M1 = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] THR_C  = CW'(BIT_THRESHOLD_CYCLES);
    localparam logic [CW-1:0] MINH_C = CW'(MIN_HIGH_CYCLES);
    localparam logic [CW-1:0] MAXH_C = CW'(MAX_HIGH_CYCLES);
    localparam logic [PW-1:0] NUM_C  = PW'(NUM_LEDS);
    localparam logic [PW-1:0] PONE   = PW'(1);

    typedef enum logic [1:0] {SYNC, LOW, HIGH} state_t;

    state_t        state;
    logic          s1, s;
    logic [CW-1:0] low_cnt, high_cnt;
    logic [4:0]    bit_cnt;
    logic [PW-1:0] pix_cnt;
    logic [23:0]   shreg;
    logic [23:0]   sh_next;

    assign sh_next = {shreg[22:0], high_cnt >= THR_C};

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state           <= SYNC;
            s1              <= 1'b0;
            s               <= 1'b0;
            low_cnt         <= '0;
            high_cnt        <= '0;
            bit_cnt         <= '0;
            pix_cnt         <= '0;
            shreg           <= '0;
            green_out       <= '0;
            red_out         <= '0;
            blue_out        <= '0;
            led_index_out   <= '0;
            pixel_valid_out <= 1'b0;
            frame_done_out  <= 1'b0;
            error_out       <= 1'b0;
        end else begin
            s1              <= strand_in;
            s               <= s1;
            pixel_valid_out <= 1'b0;
            frame_done_out  <= 1'b0;
            error_out       <= 1'b0;
            case (state)
                SYNC: begin
                    if (s) begin
                        low_cnt <= '0;
                    end else if (low_cnt != RST_C) begin
                        low_cnt <= low_cnt + ONE;
                        if (low_cnt == RST_M1) begin
                            state   <= LOW;
                            bit_cnt <= '0;
                            pix_cnt <= '0;
                        end
                    end
                end
                LOW: begin
                    if (s) begin
                        state    <= HIGH;
                        high_cnt <= ONE;
                        low_cnt  <= '0;
                    end else if (low_cnt != RST_C) begin
                        // Saturation at RST_C keeps the latch event to one per low period.
                        low_cnt <= low_cnt + ONE;
                        if (low_cnt == RST_M1 && (bit_cnt != '0 || pix_cnt != '0)) begin
                            frame_done_out <= 1'b1;
                            error_out      <= (bit_cnt != '0);
                            bit_cnt        <= '0;
                            pix_cnt        <= '0;
                        end
                    end
                end
                HIGH: begin
                    if (s) begin
                        if (high_cnt >= MAXH_C) begin
                            error_out <= 1'b1;
                            state     <= SYNC;
                            low_cnt   <= '0;
                        end else begin
                            high_cnt <= high_cnt + ONE;
                        end
                    end else if (high_cnt < MINH_C) begin
                        error_out <= 1'b1;
                        state     <= SYNC;
                        low_cnt   <= '0;
                    end else begin
                        shreg   <= sh_next;
                        state   <= LOW;
                        low_cnt <= ONE;
                        if (bit_cnt == 5'd23) begin
                            bit_cnt <= '0;
                            if (pix_cnt < NUM_C) begin
                                green_out       <= sh_next[23:16];
                                red_out         <= sh_next[15:8];
                                blue_out        <= sh_next[7:0];
                                led_index_out   <= IW'(pix_cnt);
                                pixel_valid_out <= 1'b1;
                                pix_cnt         <= pix_cnt + PONE;
                            end else begin
                                error_out <= 1'b1;
                                pix_cnt   <= NUM_C;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end
                default: state <= SYNC;
            endcase
        end
    end
endmodule

// File: tb/tb_strand_decoder.sv
// Randomized bench for strand_decoder: a pulse-level protocol model predicts
// strobes (with their cycle) into a queue; a monitor compares DUT strobes.
module tb_strand_decoder;
    localparam int N    = 10;
    localparam int THR  = 60;
    localparam int MINH = 20;
    localparam int MAXH = 110;
    localparam int RSTC = 1000;
    localparam int IW   = $clog2(N);
    localparam int LONG = RSTC + 200;
    localparam int PV = 4, FD = 2, ER = 1;

    typedef struct {
        int          code;
        int          cyc;
        logic [23:0] pix;
        int          idx;
    } ev_t;

    logic          clk = 0, rst = 1, strand = 0;
    logic [7:0]    green, red, blue;
    logic [IW-1:0] led_index;
    logic          pixel_valid, frame_done, error;

    int  cyc = 0;
    int  errors = 0, checks = 0;
    ev_t expq[$];

    bit          synced = 0;
    int          bits = 0, pix = 0;
    logic [23:0] word = '0;
    logic [23:0] last_pix = '0;

    strand_decoder #(.NUM_LEDS(N), .BIT_THRESHOLD_CYCLES(THR), .MIN_HIGH_CYCLES(MINH),
                     .MAX_HIGH_CYCLES(MAXH), .RESET_CYCLES(RSTC)) dut (
        .clk_in(clk), .rst_in(rst), .strand_in(strand),
        .green_out(green), .red_out(red), .blue_out(blue), .led_index_out(led_index),
        .pixel_valid_out(pixel_valid), .frame_done_out(frame_done), .error_out(error));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, req, req, cyc);
        end
    endtask

    function automatic void push(int code, int c, logic [23:0] p, int idx);
        ev_t e;
        e.code = code; e.cyc = c; e.pix = p; e.idx = idx;
        expq.push_back(e);
        if (code == PV) last_pix = p;
    endfunction

    // Protocol model: one high pulse of width w rising at cycle rise.
    function automatic void model_pulse(int w, int rise);
        int fall = rise + w;
        if (!synced) return;
        if (w > MAXH) begin
            push(ER, rise + 3 + MAXH, '0, 0); synced = 0;
        end else if (w < MINH) begin
            push(ER, fall + 3, '0, 0); synced = 0;
        end else begin
            word = {word[22:0], w >= THR};
            bits++;
            if (bits == 24) begin
                bits = 0;
                if (pix < N) begin push(PV, fall + 3, word, pix); pix++; end
                else push(ER, fall + 3, '0, 0);
            end
        end
    endfunction

    // Protocol model: a low period of len cycles starting at cycle fall.
    function automatic void model_gap(int len, int fall);
        if (len < RSTC) return;
        if (!synced) begin
            synced = 1; bits = 0; pix = 0;
        end else if (bits != 0 || pix != 0) begin
            push(FD | ((bits != 0) ? ER : 0), fall + 2 + RSTC, '0, 0);
            bits = 0; pix = 0;
        end
    endfunction

    task automatic pulse(int w, int gap);
        int rise;
        @(negedge clk);
        strand = 1; rise = cyc;
        model_pulse(w, rise);
        repeat (w) @(negedge clk);
        strand = 0;
        model_gap(gap, rise + w);
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic idle(int len);
        @(negedge clk);
        strand = 0;
        model_gap(len, cyc);
        repeat (len - 1) @(negedge clk);
    endtask

    // w0/w1 = 0 selects random legal widths, per = 0 selects short random gaps.
    task automatic send_bits(logic [23:0] px, int n, int w0, int w1, int per, int last_gap);
        for (int i = 0; i < n; i++) begin
            automatic bit b = px[23-i];
            automatic int w = b ? ((w1 != 0) ? w1 : $urandom_range(THR, THR + 10))
                                : ((w0 != 0) ? w0 : $urandom_range(MINH, MINH + 10));
            automatic int g = (per != 0) ? per - w : $urandom_range(2, 6);
            pulse(w, (i == n - 1) ? last_gap : g);
        end
    endtask

    task automatic send_frame(int count, logic [23:0] base);
        for (int p = 0; p < count; p++)
            send_bits(base + 24'(p * 24'h010101), 24, 0, 0, 0, (p == count - 1) ? LONG : 4);
    endtask

    always @(negedge clk) begin
        if (!rst && (pixel_valid || frame_done || error)) begin
            automatic int code = {29'd0, pixel_valid, frame_done, error};
            if (expq.size() == 0) begin
                check("unexpected_strobe", code, 0);
            end else begin
                automatic ev_t e = expq.pop_front();
                check("strobe_kind", code, e.code);
                check("strobe_cycle", cyc, e.cyc);
                if (e.code == PV) begin
                    check("pixel_grb", {8'd0, green, red, blue}, {8'd0, e.pix});
                    check("pixel_index", int'(led_index), e.idx);
                end
            end
        end
    end

    initial begin
        #1;
        check("reset_outputs", {green, red, blue, 4'(led_index), pixel_valid, frame_done, error}, 0);
        repeat (3) @(negedge clk);
        rst = 0;
        idle(LONG);

        send_bits(24'hA53CF0, 24, 40, 80, 125, LONG);
        check("hold_after_frame", {8'd0, green, red, blue}, {8'd0, last_pix});

        send_frame(N, 24'h102030);
        send_frame(N, 24'h405060);
        send_frame(N + 1, 24'h0F1E2D);

        send_bits(24'hABC000, 12, 0, 0, 0, LONG);
        send_bits(24'h123456, 24, 0, 0, 0, LONG);

        pulse(10, LONG);
        send_bits(24'h00FF81, 24, 0, 0, 0, LONG);
        pulse(200, LONG);
        send_bits(24'h7E1899, 24, 0, 0, 0, LONG);

        send_bits(24'h5AA5C3, 24, 59, 60, 0, 4);
        send_bits(24'h96E70F, 24, 20, 110, 0, LONG);
        pulse(19, LONG);
        pulse(111, LONG);

        for (int k = 0; k < 5; k++)
            send_bits(24'($urandom), 24, 0, 0, 0, (k == 4) ? LONG : $urandom_range(2, 40));
        check("hold_after_random", {8'd0, green, red, blue}, {8'd0, last_pix});

        send_bits(24'hFFFFFF, 8, 0, 0, 0, 4);
        @(negedge clk);
        #2 rst = 1;
        #1 check("midframe_reset_outputs", {green, red, blue, 4'(led_index), pixel_valid, frame_done, error}, 0);
        synced = 0; bits = 0; pix = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        send_bits(24'hC0FFEE, 6, 0, 0, 0, 4);
        idle(LONG);
        send_bits(24'h31D4E2, 24, 0, 0, 0, LONG);

        repeat (10) @(negedge clk);
        check("queue_drained", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
